// File: rtl/decode_queue_pkg.sv
// Shared fetch/decode pipeline definitions: the packed queue entry, the NOP
// bubble instruction and small helpers for building entries.
package decode_queue_pkg;

    // addi x0, x0, 0 -- what decode sees when no real instruction is available
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // All fetch payload fields travel as one word so they can never drift
    // apart between entries.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pc_src_pred;
        logic [31:0] pc_plus4;
        logic [31:0] pred_pc_target;
    } dq_entry_t;

    // Entry presented to decode while the queue is empty
    function automatic dq_entry_t dq_bubble();
        dq_entry_t b;
        b       = '0;
        b.instr = NOP_INSTR;
        return b;
    endfunction

    // Assemble an entry from the individual fetch fields
    function automatic dq_entry_t dq_pack(
        input logic [31:0] pc,
        input logic [31:0] instr,
        input logic        pc_src_pred,
        input logic [31:0] pc_plus4,
        input logic [31:0] pred_pc_target
    );
        dq_entry_t e;
        e.pc             = pc;
        e.instr          = instr;
        e.pc_src_pred    = pc_src_pred;
        e.pc_plus4       = pc_plus4;
        e.pred_pc_target = pred_pc_target;
        return e;
    endfunction

endpackage

// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue. Entries are written at the write pointer
// and presented from the read pointer with no fall-through path: a pushed
// entry becomes visible one cycle later. Flush and reset clear only the
// pointers and occupancy; the storage array keeps its stale contents.
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int ALMOST_FULL_LVL = DEPTH - 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,

    input  logic                   valid_f_i,
    output logic                   ready_f_o,
    input  logic [31:0]            instr_f_i,
    input  logic [31:0]            pc_f_i,
    input  logic [31:0]            pc_plus4_f_i,
    input  logic [31:0]            pred_pc_target_f_i,
    input  logic                   pc_src_pred_f_i,

    output logic                   valid_d_o,
    input  logic                   ready_d_i,
    output logic [31:0]            instr_d_o,
    output logic [31:0]            pc_d_o,
    output logic [31:0]            pc_plus4_d_o,
    output logic [31:0]            pred_pc_target_d_o,
    output logic                   pc_src_pred_d_o,

    output logic [$clog2(DEPTH):0] count_o,
    output logic                   almost_full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_LVL);

    dq_entry_t              mem [DEPTH];
    dq_entry_t              wr_entry;
    dq_entry_t              head;

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic                   push;
    logic                   pop;

    // Occupancy update: a simultaneous push and pop leaves it unchanged
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        case ({inc, dec})
            2'b10:   return cur + CNT_W'(1);
            2'b01:   return cur - CNT_W'(1);
            default: return cur;
        endcase
    endfunction

    // Handshake status is derived purely from the registered occupancy
    always_comb begin
        ready_f_o     = (count < FULL_CNT);
        valid_d_o     = (count != '0);
        almost_full_o = (count >= AF_CNT);
        count_o       = count;
    end

    // Flush overrides both handshakes; a full queue refuses pushes even
    // when the head is leaving in the same cycle
    always_comb begin
        push = valid_f_i && ready_f_o && !flush_i;
        pop  = valid_d_o && ready_d_i && !flush_i;
    end

    // Pack the incoming fetch fields into one storage word
    always_comb begin
        wr_entry = dq_pack(pc_f_i, instr_f_i, pc_src_pred_f_i,
                           pc_plus4_f_i, pred_pc_target_f_i);
    end

    // Pointer and occupancy control; reset acts immediately, flush on the edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= next_count(count, push, pop);
        end
    end

    // Entry storage, deliberately left out of reset and flush
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Head selection: the stored entry when valid, otherwise a NOP bubble
    always_comb begin
        head = dq_bubble();
        if (valid_d_o) begin
            head = mem[rd_ptr];
        end
    end

    // Unpack the head entry onto the decode-side ports
    always_comb begin
        instr_d_o          = head.instr;
        pc_d_o             = head.pc;
        pc_plus4_d_o       = head.pc_plus4;
        pred_pc_target_d_o = head.pred_pc_target;
        pc_src_pred_d_o    = head.pc_src_pred;
    end

endmodule
